// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU ops,
// data-processing commands and ARM condition codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_LINK,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // nzcv is {N, Z, C, V}
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_met = z;
            COND_NE: cond_met = ~z;
            COND_CS: cond_met = c;
            COND_CC: cond_met = ~c;
            COND_MI: cond_met = n;
            COND_PL: cond_met = ~n;
            COND_VS: cond_met = v;
            COND_VC: cond_met = ~v;
            COND_HI: cond_met = c & ~z;
            COND_LS: cond_met = ~c | z;
            COND_GE: cond_met = (n == v);
            COND_LT: cond_met = (n != v);
            COND_GT: cond_met = ~z & (n == v);
            COND_LE: cond_met = z | (n != v);
            COND_AL: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Architectural NZCV register plus condition evaluation; flag groups are
// written only when the instruction's condition passes.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       flag_en,
    output logic [3:0] flags,
    output logic       cond_ex
);

    assign cond_ex = cond_met(cond, flags);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else if (flag_en && cond_ex) begin
            if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control unit: main FSM, instruction decode and
// datapath strobe/select generation.
//
//  state      | meaning
//  FETCH      | read instruction, PC+4; waits on MemReady
//  DECODE     | read registers, steer by op
//  MEMADR     | compute load/store address
//  MEMREAD    | load access, held until MemReady
//  MEMWB      | write loaded data to Rd
//  MEMWRITE   | store access, held until MemReady
//  EXECUTER   | data-processing, register operand
//  EXECUTEI   | data-processing, immediate operand
//  ALUWB      | write ALU result to Rd
//  LINK       | write return address to R14
//  BRANCH     | load branch target into PC
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 2,
    parameter bit HAS_LINK  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:12]         Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 NoWrite,
    output logic                 LinkWrite,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags
);

    state_t     state;
    logic [1:0] op;
    logic [3:0] cmd;
    logic [2:0] dp_alu, alu_sel;
    logic       dp_valid, no_write, cv_arith, cond_ex, flag_en;
    logic [1:0] flag_w;
    logic       unused_bits;

    assign op          = Instr[27:26];
    assign cmd         = Instr[24:21];
    assign unused_bits = ^Instr[19:12];
    assign ImmSrc      = op;
    assign RegSrc      = {(op == OP_MEM) && !Instr[20], op == OP_BR};

    always_comb begin
        dp_alu   = ALU_ADD;
        dp_valid = 1'b1;
        no_write = 1'b0;
        cv_arith = 1'b0;
        case (cmd)
            CMD_ADD: cv_arith = 1'b1;
            CMD_SUB: begin dp_alu = ALU_SUB; cv_arith = 1'b1; end
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_EOR: begin
                if (ALUCTRL_W >= 3) dp_alu = ALU_EOR;
                else                dp_valid = 1'b0;
            end
            CMD_CMP: begin dp_alu = ALU_SUB; no_write = 1'b1; cv_arith = 1'b1; end
            CMD_TST: begin dp_alu = ALU_AND; no_write = 1'b1; end
            CMD_CMN: begin no_write = 1'b1; cv_arith = 1'b1; end
            default: dp_valid = 1'b0;
        endcase
    end

    assign flag_w  = {Instr[20] & dp_valid, Instr[20] & dp_valid & cv_arith};
    assign flag_en = (state == S_EXECUTER) || (state == S_EXECUTEI);

    cond_unit u_cond (
        .clk      (clk),
        .reset    (reset),
        .cond     (Instr[31:28]),
        .alu_flags(ALUFlags),
        .flag_w   (flag_w),
        .flag_en  (flag_en),
        .flags    (Flags),
        .cond_ex  (cond_ex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= Instr[25] ? S_EXECUTEI : S_EXECUTER;
                        OP_BR:   state <= (Instr[24] && HAS_LINK) ? S_LINK : S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= Instr[20] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (MemReady) state <= S_MEMWB;
                S_MEMWRITE: if (MemReady) state <= S_FETCH;
                S_EXECUTER,
                S_EXECUTEI: state <= S_ALUWB;
                S_LINK:     state <= S_BRANCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        NoWrite   = 1'b0;
        LinkWrite = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        alu_sel   = ALU_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
            end
            S_EXECUTER: begin
                alu_sel = dp_alu;
                NoWrite = no_write;
            end
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_sel = dp_alu;
                NoWrite = no_write;
            end
            S_ALUWB: begin
                NoWrite  = no_write;
                RegWrite = cond_ex & ~no_write & dp_valid;
            end
            S_LINK: begin
                ResultSrc = 2'b11;
                LinkWrite = 1'b1;
                RegWrite  = cond_ex;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: ;
        endcase
        // reset lands the FSM in FETCH, which would otherwise strobe on MemReady
        if (!reset) begin
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IRWrite   = 1'b0;
            NoWrite   = 1'b0;
            LinkWrite = 1'b0;
        end
    end

    assign ALUControl = ALUCTRL_W'(alu_sel);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: default, no-link and 3-bit-ALU
// instances run in lockstep; expected per-cycle outputs are queued and checked.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:12] instr;
    logic [3:0]  aluflags;
    logic        memready;

    logic        pcw [3], memw [3], regw [3], irw [3], adr [3], nowr [3], linkw [3];
    logic [1:0]  regsrc [3], asa [3], asb [3], rs [3], imm [3];
    logic [3:0]  flags [3];
    logic [1:0]  aluc0, aluc1;
    logic [2:0]  aluc2;

    always #5 clk = ~clk;

    multicycle_ctrl dut0 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(aluflags), .MemReady(memready),
        .PCWrite(pcw[0]), .MemWrite(memw[0]), .RegWrite(regw[0]), .IRWrite(irw[0]),
        .AdrSrc(adr[0]), .NoWrite(nowr[0]), .LinkWrite(linkw[0]), .RegSrc(regsrc[0]),
        .ALUSrcA(asa[0]), .ALUSrcB(asb[0]), .ResultSrc(rs[0]), .ImmSrc(imm[0]),
        .ALUControl(aluc0), .Flags(flags[0])
    );

    multicycle_ctrl #(.HAS_LINK(1'b0)) dut1 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(aluflags), .MemReady(memready),
        .PCWrite(pcw[1]), .MemWrite(memw[1]), .RegWrite(regw[1]), .IRWrite(irw[1]),
        .AdrSrc(adr[1]), .NoWrite(nowr[1]), .LinkWrite(linkw[1]), .RegSrc(regsrc[1]),
        .ALUSrcA(asa[1]), .ALUSrcB(asb[1]), .ResultSrc(rs[1]), .ImmSrc(imm[1]),
        .ALUControl(aluc1), .Flags(flags[1])
    );

    multicycle_ctrl #(.ALUCTRL_W(3)) dut2 (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(aluflags), .MemReady(memready),
        .PCWrite(pcw[2]), .MemWrite(memw[2]), .RegWrite(regw[2]), .IRWrite(irw[2]),
        .AdrSrc(adr[2]), .NoWrite(nowr[2]), .LinkWrite(linkw[2]), .RegSrc(regsrc[2]),
        .ALUSrcA(asa[2]), .ALUSrcB(asb[2]), .ResultSrc(rs[2]), .ImmSrc(imm[2]),
        .ALUControl(aluc2), .Flags(flags[2])
    );

    typedef struct {
        string       nm;
        int          which;
        logic [23:0] v;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_dec;

    // strobe order {PCWrite, MemWrite, RegWrite, IRWrite, LinkWrite, NoWrite, AdrSrc}
    localparam logic [6:0] ST_NONE = 7'b0000000;
    localparam logic [6:0] ST_REGW = 7'b0010000;
    localparam logic [6:0] ST_NOWR = 7'b0000010;
    localparam logic [6:0] ST_ADR  = 7'b0000001;
    localparam logic [6:0] ST_MEMW = 7'b0100001;
    localparam logic [6:0] ST_PCW  = 7'b1000000;
    localparam logic [6:0] ST_LINK = 7'b0010100;

    function automatic logic [23:0] act(input int k);
        logic [2:0] a3;
        a3 = (k == 0) ? {1'b0, aluc0} : (k == 1) ? {1'b0, aluc1} : aluc2;
        return {regsrc[k], imm[k], pcw[k], memw[k], regw[k], irw[k], linkw[k], nowr[k],
                adr[k], asa[k], asb[k], rs[k], a3, flags[k]};
    endfunction

    function automatic logic [19:0] mk(input logic [6:0] st, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] r,
                                       input logic [2:0] al, input logic [3:0] fl);
        return {st, sa, sb, r, al, fl};
    endfunction

    function automatic logic [19:0] fetch(input logic mr, input logic [3:0] fl);
        return mk({mr, 1'b0, 1'b0, mr, 3'b000}, 2'b01, 2'b10, 2'b10, 3'd0, fl);
    endfunction

    function automatic logic [19:0] dec(input logic [3:0] fl);
        return mk(ST_NONE, 2'b01, 2'b10, 2'b00, 3'd0, fl);
    endfunction

    task automatic set_instr(input logic [19:0] i, input logic [3:0] d);
        instr   = i;
        exp_dec = d;
    endtask

    task automatic push(input int w, input string nm, input logic [19:0] v);
        exp_t e;
        e.nm    = nm;
        e.which = w;
        e.v     = {exp_dec, v};
        q.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic rv, input logic mr,
                       input logic [3:0] af, input logic [19:0] v);
        reset    = rv;
        memready = mr;
        aluflags = af;
        push(0, nm, v);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [23:0] a;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = act(e.which);
                n_tests++;
                if (a !== e.v) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: got %b expected %b", e.nm, e.which, a, e.v);
                end
            end
        end
    end

    initial begin : stim
        reset    = 1'b0;
        memready = 1'b0;
        aluflags = 4'b0000;
        set_instr(20'hE0811, 4'b0000);
        @(posedge clk);
        #1;

        push(1, "reset_hold", mk(ST_NONE, 2'b01, 2'b10, 2'b10, 3'd0, 4'b0000));
        push(2, "reset_hold", mk(ST_NONE, 2'b01, 2'b10, 2'b10, 3'd0, 4'b0000));
        cyc("reset_hold", 1'b0, 1'b1, 4'h0, mk(ST_NONE, 2'b01, 2'b10, 2'b10, 3'd0, 4'b0000));

        // ADD R1: fetch stall then FETCH, DECODE, EXECUTER, ALUWB
        cyc("add_fetch_stall", 1'b1, 1'b0, 4'h0, fetch(1'b0, 4'b0000));
        cyc("add_fetch",       1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b0000));
        cyc("add_decode",      1'b1, 1'b0, 4'h0, dec(4'b0000));
        cyc("add_exec",        1'b1, 1'b0, 4'h0, mk(ST_NONE, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0000));
        cyc("add_wb",          1'b1, 1'b0, 4'h0, mk(ST_REGW, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0000));

        // CMP sets Z, never writes a register
        set_instr(20'hE1500, 4'b0000);
        cyc("cmp_fetch",  1'b1, 1'b1, 4'h0,    fetch(1'b1, 4'b0000));
        cyc("cmp_decode", 1'b1, 1'b0, 4'h0,    dec(4'b0000));
        cyc("cmp_exec",   1'b1, 1'b0, 4'b0100, mk(ST_NOWR, 2'b00, 2'b00, 2'b00, 3'd1, 4'b0000));
        cyc("cmp_wb",     1'b1, 1'b0, 4'h0,    mk(ST_NOWR, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100));

        // BEQ taken, BNE not taken
        set_instr(20'h0A000, 4'b0110);
        cyc("beq_fetch",  1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b0100));
        cyc("beq_decode", 1'b1, 1'b0, 4'h0, dec(4'b0100));
        cyc("beq_branch", 1'b1, 1'b0, 4'h0, mk(ST_PCW, 2'b00, 2'b01, 2'b10, 3'd0, 4'b0100));
        set_instr(20'h1A000, 4'b0110);
        cyc("bne_fetch",  1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b0100));
        cyc("bne_decode", 1'b1, 1'b0, 4'h0, dec(4'b0100));
        cyc("bne_branch", 1'b1, 1'b0, 4'h0, mk(ST_NONE, 2'b00, 2'b01, 2'b10, 3'd0, 4'b0100));

        // STR: MemWrite held through 3 stall cycles plus the ready cycle
        set_instr(20'hE5800, 4'b1001);
        cyc("str_fetch",  1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b0100));
        cyc("str_decode", 1'b1, 1'b0, 4'h0, dec(4'b0100));
        cyc("str_memadr", 1'b1, 1'b0, 4'h0, mk(ST_NONE, 2'b00, 2'b01, 2'b00, 3'd0, 4'b0100));
        for (int i = 0; i < 3; i++)
            cyc("str_stall", 1'b1, 1'b0, 4'h0, mk(ST_MEMW, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100));
        cyc("str_ready",  1'b1, 1'b1, 4'h0, mk(ST_MEMW, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100));

        // LDR with one stall cycle
        set_instr(20'hE5900, 4'b0001);
        cyc("ldr_fetch",  1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b0100));
        cyc("ldr_decode", 1'b1, 1'b0, 4'h0, dec(4'b0100));
        cyc("ldr_memadr", 1'b1, 1'b0, 4'h0, mk(ST_NONE, 2'b00, 2'b01, 2'b00, 3'd0, 4'b0100));
        cyc("ldr_stall",  1'b1, 1'b0, 4'h0, mk(ST_ADR, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100));
        cyc("ldr_ready",  1'b1, 1'b1, 4'h0, mk(ST_ADR, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100));
        cyc("ldr_wb",     1'b1, 1'b0, 4'h0, mk(ST_REGW, 2'b00, 2'b00, 2'b01, 3'd0, 4'b0100));

        // BL: LINK then BRANCH; the no-link instance skips LINK
        set_instr(20'hEB000, 4'b0110);
        push(1, "bl_fetch", fetch(1'b1, 4'b0100));
        cyc("bl_fetch", 1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b0100));
        push(1, "bl_decode", dec(4'b0100));
        cyc("bl_decode", 1'b1, 1'b0, 4'h0, dec(4'b0100));
        push(1, "bl_nolink_branch", mk(ST_PCW, 2'b00, 2'b01, 2'b10, 3'd0, 4'b0100));
        cyc("bl_link", 1'b1, 1'b0, 4'h0, mk(ST_LINK, 2'b00, 2'b00, 2'b11, 3'd0, 4'b0100));
        push(1, "bl_nolink_fetch", fetch(1'b0, 4'b0100));
        cyc("bl_branch", 1'b1, 1'b0, 4'h0, mk(ST_PCW, 2'b00, 2'b01, 2'b10, 3'd0, 4'b0100));

        // EORS: no-op at 2-bit ALUControl, real EOR at 3-bit
        set_instr(20'hE0300, 4'b0000);
        cyc("eor_fetch_stall", 1'b1, 1'b0, 4'h0, fetch(1'b0, 4'b0100));
        cyc("eor_fetch",  1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b0100));
        cyc("eor_decode", 1'b1, 1'b0, 4'h0, dec(4'b0100));
        push(2, "eor_w3_exec", mk(ST_NONE, 2'b00, 2'b00, 2'b00, 3'd4, 4'b0100));
        cyc("eor_exec", 1'b1, 1'b0, 4'b1010, mk(ST_NONE, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100));
        push(2, "eor_w3_wb", mk(ST_REGW, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1000));
        cyc("eor_wb", 1'b1, 1'b0, 4'h0, mk(ST_NONE, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100));

        // ORRS immediate: only NZ updated
        set_instr(20'hE3900, 4'b0000);
        cyc("orr_fetch",  1'b1, 1'b1, 4'h0,    fetch(1'b1, 4'b0100));
        cyc("orr_decode", 1'b1, 1'b0, 4'h0,    dec(4'b0100));
        cyc("orr_exec",   1'b1, 1'b0, 4'b1111, mk(ST_NONE, 2'b00, 2'b01, 2'b00, 3'd3, 4'b0100));
        cyc("orr_wb",     1'b1, 1'b0, 4'h0,    mk(ST_REGW, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1100));

        // ADDSNE with Z set: condition fails, no write, no flag update
        set_instr(20'h10900, 4'b0000);
        cyc("addne_fetch",  1'b1, 1'b1, 4'h0,    fetch(1'b1, 4'b1100));
        cyc("addne_decode", 1'b1, 1'b0, 4'h0,    dec(4'b1100));
        cyc("addne_exec",   1'b1, 1'b0, 4'b0011, mk(ST_NONE, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1100));
        cyc("addne_wb",     1'b1, 1'b0, 4'h0,    mk(ST_NONE, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1100));

        // CMN drives all four flags to 1
        set_instr(20'hE1700, 4'b0000);
        cyc("cmn_fetch",  1'b1, 1'b1, 4'h0,    fetch(1'b1, 4'b1100));
        cyc("cmn_decode", 1'b1, 1'b0, 4'h0,    dec(4'b1100));
        cyc("cmn_exec",   1'b1, 1'b0, 4'b1111, mk(ST_NOWR, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1100));
        cyc("cmn_wb",     1'b1, 1'b0, 4'h0,    mk(ST_NOWR, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1111));

        // reset during a stalled load: immediate FETCH and cleared flags
        set_instr(20'hE5900, 4'b0001);
        cyc("rst_ldr_fetch",  1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b1111));
        cyc("rst_ldr_decode", 1'b1, 1'b0, 4'h0, dec(4'b1111));
        cyc("rst_ldr_memadr", 1'b1, 1'b0, 4'h0, mk(ST_NONE, 2'b00, 2'b01, 2'b00, 3'd0, 4'b1111));
        cyc("rst_ldr_stall",  1'b1, 1'b0, 4'h0, mk(ST_ADR, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1111));
        cyc("rst_mid_access", 1'b0, 1'b1, 4'h0, mk(ST_NONE, 2'b01, 2'b10, 2'b10, 3'd0, 4'b0000));
        cyc("rst_release",    1'b1, 1'b1, 4'h0, fetch(1'b1, 4'b0000));

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALUCTRL_W, default 2, ALUControl width; 2 = ADD/SUB/AND/ORR; 3 adds EOR.
REQ-002 Parameter HAS_LINK, default 1, enables BL (link) support.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 Instr  in  20 (31:12)  instruction register fields.
REQ-006 ALUFlags  in  4  NZCV from ALU, current cycle.
REQ-007 MemReady  in  1  memory accepts/returns the current access this cycle.
REQ-008 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, NoWrite, LinkWrite  out  1 each  datapath strobes/selects; LinkWrite forces destination R14.
REQ-009 RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath mux selects; ResultSrc 11 = PC register.
REQ-010 ALUControl  out  ALUCTRL_W  ALU op: ADD 0, SUB 1, AND 2, ORR 3, EOR 4.
REQ-011 Flags  out  4  architectural NZCV register.

Function
REQ-012 Main FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, LINK, BRANCH, one state per cycle unless stalled.
REQ-013 FETCH: AdrSrc 0, ALUSrcA 01, ALUSrcB 10, ADD, ResultSrc 10; IRWrite and PCWrite only in the cycle MemReady=1; stay in FETCH while MemReady=0.
REQ-014 DECODE: ALUSrcA 01, ALUSrcB 10, ADD; next = MEMADR (op 01), EXECUTER (op 00, I=0), EXECUTEI (op 00, I=1), LINK (op 10, L=1, HAS_LINK=1), BRANCH (op 10 otherwise), FETCH (op 11, no-op).
REQ-015 MEMADR: ALUSrcA 00, ALUSrcB 01, ADD; next MEMREAD (L=1) else MEMWRITE.
REQ-016 MEMREAD: AdrSrc 1; hold until MemReady=1, then MEMWB; MEMWB: ResultSrc 01, RegWrite if CondEx, then FETCH.
REQ-017 MEMWRITE: AdrSrc 1, MemWrite=CondEx every cycle until MemReady=1 inclusive, then FETCH.
REQ-018 EXECUTER: ALUSrcB 00; EXECUTEI: ALUSrcB 01; both ALUSrcA 00, decoded ALUControl, next ALUWB.
REQ-019 Cmd decode Instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1010 CMP(SUB), 1000 TST(AND), 1011 CMN(ADD); EOR when ALUCTRL_W=2, or any other cmd, is a no-op (no RegWrite, no flag write).
REQ-020 NoWrite=1 for CMP/TST/CMN; ALUWB: ResultSrc 00, RegWrite = CondEx & ~NoWrite, then FETCH.
REQ-021 FlagW[1] (NZ) = S; FlagW[0] (CV) = S & cmd in {ADD,SUB,CMP,CMN}; Flags updated from ALUFlags at end of EXECUTER/EXECUTEI when CondEx.
REQ-022 LINK: ResultSrc 11, LinkWrite 1, RegWrite=CondEx, then BRANCH.
REQ-023 BRANCH: ALUSrcA 00, ALUSrcB 01, ADD, ResultSrc 10, PCWrite=CondEx, then FETCH.
REQ-024 CondEx from Instr[31:28] vs registered Flags, standard 14 ARM codes; 1110 always true; 1111 always false.
REQ-025 ImmSrc = Instr[27:26]; RegSrc[0] = branch op, RegSrc[1] = store (op 01, L=0).
REQ-026 All strobes not named for a state are 0; selects not named are 00.

Reset
REQ-027 reset=0 asynchronously forces state FETCH and Flags 0000; all strobes 0 while reset=0.
REQ-028 Reset mid-access (MEMREAD/MEMWRITE stall) abandons the access; first cycle after release is FETCH.

Structure
REQ-029 Package ctrl_pkg holds state enum, ALU op codes, condition-code constants, cmd encodings.
REQ-030 One sub-module cond_unit: Flags register, CondEx evaluation, FlagW gating.

Verification
REQ-031 ADD R1 (E0811002), MemReady=1 -> FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 only in ALUWB.
REQ-032 CMP then BEQ with Z=1 -> Flags.Z=1, RegWrite never asserted for CMP, PCWrite=1 in BRANCH.
REQ-033 STR with MemReady low 3 cycles in MEMWRITE -> MemWrite high 4 cycles, one FETCH follows.
REQ-034 BL (EB000004) -> LINK: LinkWrite=1, ResultSrc 11, RegWrite=1; BRANCH: PCWrite=1; HAS_LINK=0 -> no LINK state.
REQ-035 EOR cmd with ALUCTRL_W=2 -> no RegWrite, Flags unchanged; ALUCTRL_W=3 -> ALUControl=4.
REQ-036 reset=0 during MEMREAD stall, Flags=1111 -> Flags 0000 immediately, FETCH after release.
